// File: rtl/dds_wave_gen_if.sv
// Configuration handshake bundle for dds_wave_gen: the control block (master) offers a
// frequency word, phase offset and waveform mode; the generator (slave) accepts them into
// its shadow register when cfg_ready is high.
interface dds_wave_gen_if #(
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned PHASE_W = 11
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [ACC_W-1:0]   cfg_k;
  logic [PHASE_W-1:0] cfg_p;
  logic [1:0]         cfg_mode;

  modport master (
    output cfg_valid,
    output cfg_k,
    output cfg_p,
    output cfg_mode,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_k,
    input  cfg_p,
    input  cfg_mode,
    output cfg_ready
  );
endinterface

// File: rtl/dds_wave_gen.sv
// Direct-digital-synthesis waveform generator: phase accumulator, phase-offset stage and
// waveform stage (square/saw/triangle/zero). New configurations wait in a shadow register and
// are applied at a period boundary, when idle, or on sync_clr, so the output never glitches.
// Optional feature: define DDS_SWEEP_EN for a linear frequency sweep on every wrap.
module dds_wave_gen #(
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned PHASE_W = 11,
  parameter int unsigned OUT_W   = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  input  logic               i_sync_clr,
  dds_wave_gen_if.slave      cfg,
  input  logic [ACC_W-1:0]   i_sweep_step,
  input  logic [ACC_W-1:0]   i_sweep_limit,
  output logic [OUT_W-1:0]   o_wave_out,
  output logic               o_out_valid,
  output logic               o_wrap
);

  logic [ACC_W-1:0]   r_acc, r_k_act, r_k_base, r_sh_k;
  logic [PHASE_W-1:0] r_p_act, r_sh_p, r_phase;
  logic [1:0]         r_mode_act, r_sh_mode, r_mode;
  logic               r_pending, r_en_d, r_out_valid, r_wrap;
  logic [OUT_W-1:0]   r_wave;

  logic [ACC_W:0]     w_sum;
  logic               w_carry, w_accept, w_apply;
  logic [ACC_W-1:0]   w_k_next;
  logic [PHASE_W-2:0] w_tri;
  logic [PHASE_W-1:0] w_tri_full;
  logic [OUT_W-1:0]   w_wave;

  assign w_sum    = {1'b0, r_acc} + {1'b0, r_k_act};
  // A carry only counts as a period boundary when the accumulator really advances.
  assign w_carry  = i_en & ~i_sync_clr & w_sum[ACC_W];
  assign w_accept = cfg.cfg_valid & ~r_pending;
  assign w_apply  = r_pending & (~i_en | i_sync_clr | w_carry);
  assign cfg.cfg_ready = ~r_pending;

`ifdef DDS_SWEEP_EN
  logic [ACC_W:0] w_sweep_sum;
  assign w_sweep_sum = {1'b0, r_k_act} + {1'b0, i_sweep_step};

  // Next tuning word: shadow apply wins, otherwise sweep on each wrap and fall back at limit.
  always_comb begin
    w_k_next = r_k_act;
    if (w_apply) begin
      w_k_next = r_sh_k;
    end else if (w_carry && (i_sweep_step != '0)) begin
      w_k_next = (w_sweep_sum >= {1'b0, i_sweep_limit}) ? r_k_base : w_sweep_sum[ACC_W-1:0];
    end
  end
`else
  logic w_unused_sweep;
  assign w_unused_sweep = ^{i_sweep_step, i_sweep_limit};

  // Next tuning word: only the shadow apply changes it.
  always_comb begin
    w_k_next = r_k_act;
    if (w_apply) begin
      w_k_next = r_sh_k;
    end
  end
`endif

  // Handshake capture into the shadow register and transfer to the active registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending  <= 1'b0;
      r_sh_k     <= '0;
      r_sh_p     <= '0;
      r_sh_mode  <= '0;
      r_k_act    <= '0;
      r_k_base   <= '0;
      r_p_act    <= '0;
      r_mode_act <= '0;
    end else begin
      r_k_act <= w_k_next;
      if (w_apply) begin
        r_pending  <= 1'b0;
        r_k_base   <= r_sh_k;
        r_p_act    <= r_sh_p;
        r_mode_act <= r_sh_mode;
      end else if (w_accept) begin
        r_pending <= 1'b1;
        r_sh_k    <= cfg.cfg_k;
        r_sh_p    <= cfg.cfg_p;
        r_sh_mode <= cfg.cfg_mode;
      end
    end
  end

  // Phase accumulator with synchronous clear and wrap pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_wrap <= 1'b0;
    end else if (i_sync_clr) begin
      r_acc  <= '0;
      r_wrap <= 1'b0;
    end else if (i_en) begin
      r_acc  <= w_sum[ACC_W-1:0];
      r_wrap <= w_sum[ACC_W];
    end else begin
      r_wrap <= 1'b0;
    end
  end

  // Waveform shaping from the offset phase.
  always_comb begin
    w_tri      = r_phase[PHASE_W-1] ? ~r_phase[PHASE_W-2:0] : r_phase[PHASE_W-2:0];
    w_tri_full = {w_tri, 1'b0};
    w_wave     = '0;
    case (r_mode)
      2'd0:    w_wave = r_phase[PHASE_W-1] ? '0 : '1;
      2'd1:    w_wave = r_phase[PHASE_W-1 -: OUT_W];
      2'd2:    w_wave = w_tri_full[PHASE_W-1 -: OUT_W];
      default: w_wave = '0;
    endcase
  end

  // Phase-offset stage and registered output stage; valid tracks en through both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase     <= '0;
      r_mode      <= '0;
      r_wave      <= '0;
      r_en_d      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_phase     <= r_acc[ACC_W-1 -: PHASE_W] + r_p_act;
      r_mode      <= r_mode_act;
      r_wave      <= w_wave;
      r_en_d      <= i_en;
      r_out_valid <= r_en_d;
    end
  end

  assign o_wave_out  = r_wave;
  assign o_out_valid = r_out_valid;
  assign o_wrap      = r_wrap;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Self-checking bench for dds_wave_gen: directed scenarios against hand-derived constants plus
// a randomized run against a cycle-level arithmetic reference model.
module tb_dds_wave_gen;
  localparam int unsigned ACC_W   = 32;
  localparam int unsigned PHASE_W = 11;
  localparam int unsigned OUT_W   = 11;
  localparam longint unsigned MOD = 64'h1_0000_0000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             sclr = 1'b0;
  logic [ACC_W-1:0] sweep_step = '0;
  logic [ACC_W-1:0] sweep_limit = '0;
  logic [OUT_W-1:0] wave_out;
  logic             out_valid;
  logic             wrap;

  dds_wave_gen_if #(.ACC_W(ACC_W), .PHASE_W(PHASE_W)) cfg_if ();

  dds_wave_gen #(.ACC_W(ACC_W), .PHASE_W(PHASE_W), .OUT_W(OUT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_en         (en),
    .i_sync_clr   (sclr),
    .cfg          (cfg_if),
    .i_sweep_step (sweep_step),
    .i_sweep_limit(sweep_limit),
    .o_wave_out   (wave_out),
    .o_out_valid  (out_valid),
    .o_wrap       (wrap)
  );

  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model state (values after the most recent edge).
  longint unsigned m_acc, m_k, m_kbase, m_sh_k;
  int              m_p, m_mode, m_sh_p, m_sh_mode;
  bit              m_pend, m_wrap;
  longint unsigned h_acc[3];
  int              h_p[3];
  int              h_mode[3];
  bit              h_en[2];

  function automatic int wavefn(input int phase, input int mode);
    case (mode)
      0:       return (phase < 1024) ? 2047 : 0;
      1:       return phase;
      2:       return (phase < 1024) ? 2 * phase : 2 * (2047 - phase);
      default: return 0;
    endcase
  endfunction

  function automatic int exp_wave();
    return wavefn(int'(((h_acc[2] >> (ACC_W - PHASE_W)) + longint'(h_p[2])) % 2048), h_mode[2]);
  endfunction

  task automatic model_reset();
    m_acc = 0; m_k = 0; m_kbase = 0; m_sh_k = 0;
    m_p = 0; m_mode = 0; m_sh_p = 0; m_sh_mode = 0;
    m_pend = 0; m_wrap = 0;
    for (int i = 0; i < 3; i++) begin
      h_acc[i] = 0; h_p[i] = 0; h_mode[i] = 0;
    end
    h_en[0] = 0; h_en[1] = 0;
  endtask

  task automatic model_edge();
    longint unsigned sum;
    bit carry, apply, accept;
    accept = cfg_if.cfg_valid && !m_pend;
    sum    = m_acc + m_k;
    carry  = en && !sclr && (sum >= MOD);
    apply  = m_pend && (!en || sclr || carry);
    if (sclr)    m_acc = 0;
    else if (en) m_acc = sum % MOD;
    m_wrap = carry;
    if (apply) begin
      m_k = m_sh_k; m_kbase = m_sh_k; m_p = m_sh_p; m_mode = m_sh_mode;
    end
`ifdef DDS_SWEEP_EN
    else if (carry && sweep_step != 0) begin
      m_k = (m_k + sweep_step >= longint'(sweep_limit)) ? m_kbase : m_k + sweep_step;
    end
`endif
    if (apply) m_pend = 0;
    else if (accept) begin
      m_pend = 1; m_sh_k = cfg_if.cfg_k; m_sh_p = int'(cfg_if.cfg_p);
      m_sh_mode = int'(cfg_if.cfg_mode);
    end
    for (int i = 2; i > 0; i--) begin
      h_acc[i] = h_acc[i-1]; h_p[i] = h_p[i-1]; h_mode[i] = h_mode[i-1];
    end
    h_acc[0] = m_acc; h_p[0] = m_p; h_mode[0] = m_mode;
    h_en[1] = h_en[0]; h_en[0] = en;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en = 0; sclr = 0; sweep_step = '0; sweep_limit = '0;
    cfg_if.cfg_valid = 0; cfg_if.cfg_k = '0; cfg_if.cfg_p = '0; cfg_if.cfg_mode = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_cfg(input logic [31:0] k, input int p, input int mode);
    en = 0;
    cfg_if.cfg_valid = 1; cfg_if.cfg_k = k;
    cfg_if.cfg_p = PHASE_W'(p); cfg_if.cfg_mode = 2'(mode);
    step();
    cfg_if.cfg_valid = 0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    load_cfg(32'h1234_5678, 3, 1);
    en = 1;
    for (int n = 0; n < 6; n++) step();
    cfg_if.cfg_valid = 1; cfg_if.cfg_k = 32'h0000_0010;
    step();
    cfg_if.cfg_valid = 0;
    // Assert reset asynchronously mid-operation with a pending config.
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (wave_out !== '0) begin failures++; $display("FAIL rst_async_wave got %0d expected 0", wave_out); end
    checks++;
    if (out_valid !== 1'b0 || wrap !== 1'b0) begin
      failures++; $display("FAIL rst_async_flags got valid=%0b wrap=%0b expected 0/0", out_valid, wrap);
    end
    do_reset();
    checks++;
    if (wave_out !== '0) begin failures++; $display("FAIL reset_wave got %0d expected 0", wave_out); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %0b expected 0", out_valid); end
    checks++;
    if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got %0b expected 0", wrap); end
    step();
    checks++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready got %0b expected 1", cfg_if.cfg_ready);
    end
  endtask

  task automatic test_saw();
    do_reset();
    load_cfg(32'h4000_0000, 0, 1);
    en = 1;
    for (int n = 1; n <= 12; n++) begin
      step();
      checks++;
      if (out_valid !== (n >= 2)) begin
        failures++; $display("FAIL saw_valid n=%0d got %0b expected %0b", n, out_valid, n >= 2);
      end
      checks++;
      if (wrap !== (n % 4 == 0)) begin
        failures++; $display("FAIL saw_wrap n=%0d got %0b expected %0b", n, wrap, n % 4 == 0);
      end
      if (n >= 2) begin
        checks++;
        if (wave_out !== OUT_W'(512 * ((n - 2) % 4))) begin
          failures++;
          $display("FAIL saw_wave n=%0d got %0d expected %0d", n, wave_out, 512 * ((n - 2) % 4));
        end
      end
    end
  endtask

  task automatic test_phase_tri();
    int exp_saw[4] = '{256, 768, 1280, 1792};
    int exp_tri[4] = '{512, 1536, 1534, 510};
    for (int mode = 1; mode <= 2; mode++) begin
      do_reset();
      load_cfg(32'h4000_0000, 256, mode);
      en = 1;
      for (int n = 1; n <= 9; n++) begin
        step();
        if (n >= 2) begin
          checks++;
          if (wave_out !== OUT_W'(mode == 1 ? exp_saw[(n-2)%4] : exp_tri[(n-2)%4])) begin
            failures++;
            $display("FAIL phase_tri mode=%0d n=%0d got %0d expected %0d", mode, n, wave_out,
                     mode == 1 ? exp_saw[(n-2)%4] : exp_tri[(n-2)%4]);
          end
        end
      end
    end
  endtask

  task automatic test_deferred();
    int exp_w[6] = '{1792, 0, 512, 1024, 1536, 0};
    do_reset();
    load_cfg(32'h2000_0000, 0, 1);
    en = 1;
    for (int n = 1; n <= 14; n++) begin
      cfg_if.cfg_valid = (n == 3);
      cfg_if.cfg_k = 32'h4000_0000;
      step();
      checks++;
      if (cfg_if.cfg_ready !== !(n >= 3 && n < 8)) begin
        failures++;
        $display("FAIL defer_ready n=%0d got %0b expected %0b", n, cfg_if.cfg_ready, !(n >= 3 && n < 8));
      end
      checks++;
      if (wrap !== (n == 8 || n == 12)) begin
        failures++; $display("FAIL defer_wrap n=%0d got %0b expected %0b", n, wrap, n == 8 || n == 12);
      end
      if (n >= 9) begin
        checks++;
        if (wave_out !== OUT_W'(exp_w[n-9])) begin
          failures++; $display("FAIL defer_wave n=%0d got %0d expected %0d", n, wave_out, exp_w[n-9]);
        end
      end
    end
    cfg_if.cfg_valid = 0;
  endtask

  task automatic test_sync_clr();
    int exp_w[5] = '{1024, 0, 512, 1024, 1536};
    do_reset();
    load_cfg(32'h2000_0000, 0, 1);
    en = 1;
    for (int n = 1; n <= 10; n++) begin
      cfg_if.cfg_valid = (n == 4);
      cfg_if.cfg_k = 32'h4000_0000;
      sclr = (n == 5);
      step();
      checks++;
      if (cfg_if.cfg_ready !== (n != 4)) begin
        failures++; $display("FAIL sclr_ready n=%0d got %0b expected %0b", n, cfg_if.cfg_ready, n != 4);
      end
      checks++;
      if (wrap !== (n == 9)) begin
        failures++; $display("FAIL sclr_wrap n=%0d got %0b expected %0b", n, wrap, n == 9);
      end
      if (n >= 2) begin
        checks++;
        if (out_valid !== 1'b1) begin
          failures++; $display("FAIL sclr_valid n=%0d got %0b expected 1", n, out_valid);
        end
      end
      if (n >= 6) begin
        checks++;
        if (wave_out !== OUT_W'(exp_w[n-6])) begin
          failures++; $display("FAIL sclr_wave n=%0d got %0d expected %0d", n, wave_out, exp_w[n-6]);
        end
      end
    end
    cfg_if.cfg_valid = 0;
    sclr = 0;
  endtask

`ifdef DDS_SWEEP_EN
  task automatic test_sweep();
    bit exp_wrap;
    do_reset();
    sweep_step  = 32'h1000_0000;
    sweep_limit = 32'h4000_0000;
    load_cfg(32'h1000_0000, 0, 1);
    en = 1;
    for (int n = 1; n <= 46; n++) begin
      step();
      exp_wrap = (n == 16 || n == 24 || n == 30 || n == 44);
      checks++;
      if (wrap !== exp_wrap) begin
        failures++; $display("FAIL sweep_wrap n=%0d got %0b expected %0b", n, wrap, exp_wrap);
      end
    end
    sweep_step  = '0;
    sweep_limit = '0;
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      en   = ($urandom % 8) != 0;
      sclr = ($urandom % 25) == 0;
      cfg_if.cfg_valid = ($urandom % 3) == 0;
      case ($urandom % 4)
        0:       cfg_if.cfg_k = '0;
        1:       cfg_if.cfg_k = $urandom >> ($urandom % 6);
        default: cfg_if.cfg_k = $urandom;
      endcase
      cfg_if.cfg_p    = PHASE_W'($urandom % 2048);
      cfg_if.cfg_mode = 2'($urandom % 4);
      sweep_step  = (($urandom % 3) == 0) ? ($urandom >> 3) : '0;
      sweep_limit = $urandom;
      step();
      checks++;
      if (wave_out !== OUT_W'(exp_wave())) begin
        failures++; $display("FAIL rand_wave n=%0d got %0d expected %0d", n, wave_out, exp_wave());
      end
      checks++;
      if (out_valid !== h_en[1]) begin
        failures++; $display("FAIL rand_valid n=%0d got %0b expected %0b", n, out_valid, h_en[1]);
      end
      checks++;
      if (wrap !== m_wrap) begin
        failures++; $display("FAIL rand_wrap n=%0d got %0b expected %0b", n, wrap, m_wrap);
      end
      checks++;
      if (cfg_if.cfg_ready !== !m_pend) begin
        failures++; $display("FAIL rand_ready n=%0d got %0b expected %0b", n, cfg_if.cfg_ready, !m_pend);
      end
    end
    cfg_if.cfg_valid = 0;
    en = 0; sclr = 0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cfg_if.cfg_valid = 0; cfg_if.cfg_k = '0; cfg_if.cfg_p = '0; cfg_if.cfg_mode = '0;
    model_reset();
    test_reset();
    test_saw();
    test_phase_tri();
    test_deferred();
    test_sync_clr();
`ifdef DDS_SWEEP_EN
    test_sweep();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
